// File: rtl/steer_emu_pkg.sv
// Shared types and widths for the digital steering / gas emulator.
// Imported by steer_gas_emu and sat_step.
package steer_emu_pkg;

   localparam int POS_W  = 8;
   localparam int SINT_W = 9;
   localparam int RATE_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      TURN_P,
      TURN_M,
      CENTER
   } steer_state_t;

   function automatic logic signed [SINT_W-1:0] rate_to_step(input logic [RATE_W-1:0] rate,
                                                              input logic             neg);
      logic signed [SINT_W-1:0] mag;
      mag = $signed({{(SINT_W-RATE_W){1'b0}}, rate});
      return neg ? -mag : mag;
   endfunction

endpackage

// File: rtl/steer_gas_emu_sat_step.sv
// Combinational saturating add of a signed step to an unsigned position,
// clamped to [lo_i, hi_i].
module sat_step
   import steer_emu_pkg::*;
(
   input  logic        [POS_W-1:0]  val_i,
   input  logic signed [SINT_W-1:0] step_i,
   input  logic        [POS_W-1:0]  lo_i,
   input  logic        [POS_W-1:0]  hi_i,
   output logic        [POS_W-1:0]  res_o
);

   localparam int SUM_W = SINT_W + 1;

   // One spare bit so val + step never wraps before the clamp sees it.
   logic signed [SUM_W-1:0] sum;

   assign sum = $signed({2'b00, val_i}) + $signed({step_i[SINT_W-1], step_i});

   always_comb begin
      if (sum < $signed({2'b00, lo_i})) begin
         res_o = lo_i;
      end else if (sum > $signed({2'b00, hi_i})) begin
         res_o = hi_i;
      end else begin
         res_o = sum[POS_W-1:0];
      end
   end

endmodule

// File: rtl/steer_gas_emu.sv
// Joystick-to-analog steering wheel and gas pedal emulator, updated once per vsync.
// Define STEER_EMU_AUTOCENTER_EN to let the wheel spring back to centre on release.
module steer_gas_emu
   import steer_emu_pkg::*;
#(
   parameter logic [7:0]  STEER_CENTER = 8'h70,
   parameter logic [7:0]  STEER_MIN    = 8'h30,
   parameter logic [7:0]  STEER_MAX    = 8'hB0,
   parameter int unsigned MAX_RATE     = 4,
   parameter int unsigned RETURN_STEP  = 2,
   parameter logic [7:0]  GAS_MIN      = 8'h00,
   parameter logic [7:0]  GAS_MAX      = 8'hFE,
   parameter int unsigned GAS_STEP     = 6
) (
   input  logic       clk_sys,
   input  logic       RESET,
   input  logic       vsync,
   input  logic       steer_plus,
   input  logic       steer_minus,
   input  logic       gas_plus,
   input  logic       gas_minus,
   output logic [7:0] steering,
   output logic [7:0] gas,
   output logic       frame_tick
);

   localparam logic        [RATE_W-1:0] RATE_CAP = RATE_W'(MAX_RATE);
   localparam logic signed [SINT_W-1:0] GAS_INC  = SINT_W'(GAS_STEP);

   logic                      vs_q, vs_qq, tick;
   logic                      frame_tick_q;
   steer_state_t              state_q, state_d;
   logic        [RATE_W-1:0]  rate_q, rate_d, rate_inc;
   logic        [POS_W-1:0]   steer_q, steer_sat;
   logic        [POS_W-1:0]   gas_q, gas_sat;
   logic signed [SINT_W-1:0]  steer_step, gas_step;
   logic                      go_p, go_m;

   assign tick     = vs_q & ~vs_qq;
   assign go_p     = steer_plus & ~steer_minus;
   assign go_m     = steer_minus & ~steer_plus;
   assign rate_inc = (rate_q >= RATE_CAP) ? RATE_CAP : rate_q + RATE_W'(1);

`ifdef STEER_EMU_AUTOCENTER_EN
   localparam logic [POS_W-1:0] RET_STEP = POS_W'(RETURN_STEP);

   logic                     ctr_above, ctr_arrive;
   logic        [POS_W-1:0]  ctr_dist, ctr_mag;
   logic signed [SINT_W-1:0] ctr_step;

   // Last return step is shortened to the remaining distance so centre is hit exactly.
   assign ctr_above  = steer_q > STEER_CENTER;
   assign ctr_dist   = ctr_above ? steer_q - STEER_CENTER : STEER_CENTER - steer_q;
   assign ctr_arrive = ctr_dist <= RET_STEP;
   assign ctr_mag    = ctr_arrive ? ctr_dist : RET_STEP;
   assign ctr_step   = ctr_above ? -$signed({1'b0, ctr_mag}) : $signed({1'b0, ctr_mag});
`endif

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      rate_d     = rate_q;
      steer_step = '0;
      if (tick) begin
         case (state_q)
            TURN_P, TURN_M: begin
               if (!go_p && !go_m) begin
`ifdef STEER_EMU_AUTOCENTER_EN
                  state_d = CENTER;
`else
                  state_d = IDLE;
`endif
                  rate_d  = '0;
               end else if ((go_p && state_q == TURN_P) || (go_m && state_q == TURN_M)) begin
                  rate_d     = rate_inc;
                  steer_step = rate_to_step(rate_inc, go_m);
               end else begin
                  state_d    = go_p ? TURN_P : TURN_M;
                  rate_d     = RATE_W'(1);
                  steer_step = rate_to_step(RATE_W'(1), go_m);
               end
            end
`ifdef STEER_EMU_AUTOCENTER_EN
            CENTER: begin
               if (go_p || go_m) begin
                  state_d    = go_p ? TURN_P : TURN_M;
                  rate_d     = RATE_W'(1);
                  steer_step = rate_to_step(RATE_W'(1), go_m);
               end else begin
                  steer_step = ctr_step;
                  if (ctr_arrive) state_d = IDLE;
               end
            end
`endif
            default: begin
               if (go_p || go_m) begin
                  state_d    = go_p ? TURN_P : TURN_M;
                  rate_d     = RATE_W'(1);
                  steer_step = rate_to_step(RATE_W'(1), go_m);
               end
            end
         endcase
      end
   end

   always_comb begin
      if (gas_plus && gas_minus) begin
         gas_step = '0;
      end else if (gas_plus) begin
         gas_step = GAS_INC;
      end else begin
         gas_step = -GAS_INC;
      end
   end

   sat_step u_steer_sat (
      .val_i  (steer_q),
      .step_i (steer_step),
      .lo_i   (STEER_MIN),
      .hi_i   (STEER_MAX),
      .res_o  (steer_sat)
   );

   sat_step u_gas_sat (
      .val_i  (gas_q),
      .step_i (gas_step),
      .lo_i   (GAS_MIN),
      .hi_i   (GAS_MAX),
      .res_o  (gas_sat)
   );

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk_sys) begin
      if (RESET) begin
         vs_q         <= 1'b0;
         vs_qq        <= 1'b0;
         frame_tick_q <= 1'b0;
         state_q      <= IDLE;
         rate_q       <= '0;
         steer_q      <= STEER_CENTER;
         gas_q        <= GAS_MIN;
      end else begin
         vs_q         <= vsync;
         vs_qq        <= vs_q;
         frame_tick_q <= tick;
         if (tick) begin
            state_q <= state_d;
            rate_q  <= rate_d;
            steer_q <= steer_sat;
            gas_q   <= gas_sat;
         end
      end
   end

   assign steering   = steer_q;
   assign gas        = gas_q | 8'h01;
   assign frame_tick = frame_tick_q;

endmodule
